dmem_responder: RTL and testbench

//  Responder end of the MEM-stage data-memory interface: accepts one load/store

---
 rtl/dmem_responder_pkg.sv | 23 ++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_responder_array.sv | 44 ++++
 rtl/dmem_responder.sv | 104 ++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// The request struct is sized by the package constants. A non-default width build must change them here.
package mips_mem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_BE_W   = DMEM_DATA_W / 8;
    localparam int DMEM_WCNT_W = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_t;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [DMEM_BE_W-1:0]   be;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int ADDR_W = mips_mem_pkg::DMEM_ADDR_W,
    parameter int DATA_W = mips_mem_pkg::DMEM_DATA_W
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Single-port synchronous word array with per-byte write enables and a registered read port.
// An access that writes returns zero on the read port, so store responses carry no data.
module dmem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_be,
    output logic [DATA_W-1:0]   o_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= i_we ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the data-memory interface. It accepts one request per handshake and waits WAIT_STATES cycles.
// It then performs the array access and pulses rsp_valid for one cycle.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    localparam logic [DMEM_WCNT_W-1:0] WAIT_LOAD = DMEM_WCNT_W'(WAIT_STATES);
    localparam bit                     NO_WAIT   = (WAIT_STATES == 0);

    dmem_state_t              r_state;
    dmem_state_t              w_next_state;
    logic [DMEM_WCNT_W-1:0]   r_wcnt;
    dmem_req_t                r_req;
    dmem_req_t                w_in_req;
    dmem_req_t                w_arr_req;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_rsp_valid;
    logic                     w_accept;
    logic                     w_enter_resp;
    logic [DATA_W-1:0]        w_rdata;

    assign w_accept = bus.req_valid && r_ready;

    assign w_in_req = '{
        we:    bus.req_we,
        addr:  bus.req_addr,
        wdata: bus.req_wdata,
        be:    bus.req_be
    };

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DMEM_IDLE: begin
                if (w_accept) w_next_state = NO_WAIT ? DMEM_RESP : DMEM_WAIT;
            end
            DMEM_WAIT: begin
                if (r_wcnt <= 4'd1) w_next_state = DMEM_RESP;
            end
            DMEM_RESP: begin
                if (w_accept) w_next_state = NO_WAIT ? DMEM_RESP : DMEM_WAIT;
                else          w_next_state = DMEM_IDLE;
            end
            default: w_next_state = DMEM_IDLE;
        endcase
    end

    // Every transition into RESP, including RESP->RESP with no wait states, is one array access.
    assign w_enter_resp = (w_next_state == DMEM_RESP);

    // With no wait states the access coincides with acceptance, so the live request feeds the array.
    assign w_arr_req = NO_WAIT ? w_in_req : r_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= DMEM_IDLE;
            r_wcnt      <= '0;
            r_req       <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_ready     <= (w_next_state != DMEM_WAIT);
            r_busy      <= (w_next_state == DMEM_WAIT);
            r_rsp_valid <= w_enter_resp;
            if (w_accept) begin
                r_req  <= w_in_req;
                r_wcnt <= WAIT_LOAD;
            end else if (r_state == DMEM_WAIT) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_enter_resp),
        .i_we    (w_arr_req.we),
        .i_addr  (w_arr_req.addr),
        .i_wdata (w_arr_req.wdata),
        .i_be    (w_arr_req.be),
        .o_rdata (w_rdata)
    );

    assign bus.req_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = w_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder. It drives one 2-wait-state instance and one 0-wait-state instance.
// Each cycle is checked against a word-array reference model.
module tb_dmem_responder;
    import mips_mem_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if2 ();
    dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();

    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(2)) dut2 (
        .clk (clk), .rst (rst), .bus (if2.slave)
    );
    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut0 (
        .clk (clk), .rst (rst), .bus (if0.slave)
    );

    typedef struct {
        bit        we;
        bit [9:0]  addr;
        bit [31:0] wdata;
        bit [3:0]  be;
    } op_t;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        bit          kn;
        bit          we;
        int          acc;
    } exp_t;

    op_t         ops[$];
    logic [31:0] m2 [1024];
    logic [31:0] m0 [1024];
    bit          k2 [1024];
    bit          k0 [1024];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_rd;
    int          last_lat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic drive(input bit sel, input bit v, input op_t o);
        if (sel) begin
            if0.req_valid = v; if0.req_we = o.we; if0.req_addr = o.addr;
            if0.req_wdata = o.wdata; if0.req_be = o.be;
        end else begin
            if2.req_valid = v; if2.req_we = o.we; if2.req_addr = o.addr;
            if2.req_wdata = o.wdata; if2.req_be = o.be;
        end
    endtask

    function automatic logic s_ready(input bit sel); return sel ? if0.req_ready : if2.req_ready; endfunction
    function automatic logic s_busy (input bit sel); return sel ? if0.busy      : if2.busy;      endfunction
    function automatic logic s_rsp  (input bit sel); return sel ? if0.rsp_valid : if2.rsp_valid; endfunction
    function automatic logic [31:0] s_rdata(input bit sel); return sel ? if0.rsp_rdata : if2.rsp_rdata; endfunction

    // Reference memory: stores merge byte lanes, loads return the word, stores answer zero.
    task automatic model_apply(input bit sel, input op_t o, output logic [31:0] exp, output bit kn);
        logic [31:0] w;
        bit          wk;
        w  = sel ? m0[o.addr] : m2[o.addr];
        wk = sel ? k0[o.addr] : k2[o.addr];
        if (o.we) begin
            for (int b = 0; b < 4; b++)
                if (o.be[b]) w[8*b +: 8] = o.wdata[8*b +: 8];
            wk = wk || (o.be == 4'hF);
            if (sel) begin m0[o.addr] = w; k0[o.addr] = wk; end
            else     begin m2[o.addr] = w; k2[o.addr] = wk; end
            exp = 32'h0;
            kn  = 1'b1;
        end else begin
            exp = w;
            kn  = wk;
        end
    endtask

    // Streams the queued ops into one DUT. Each accepted request is due back exactly ws+1 cycles later.
    task automatic run_ops(input bit sel, input int gap_pct, input int ws);
        exp_t        eq[$];
        exp_t        e;
        op_t         cur;
        bit          presenting = 0;
        bit          rv_exp, busy_exp, kn;
        logic [31:0] d;
        int          t = 0;
        int          limit;
        cur   = '{0, 0, 0, 0};
        limit = ops.size() * (ws + 1) * 4 + 50;
        while ((ops.size() > 0 || eq.size() > 0 || presenting) && t < limit) begin
            @(posedge clk); #1;
            if (!presenting && ops.size() > 0 && $urandom_range(99) >= gap_pct) begin
                cur = ops.pop_front();
                presenting = 1;
            end
            drive(sel, presenting, cur);
            @(negedge clk); t++;
            rv_exp = (eq.size() > 0) && (eq[0].cyc == t);
            check_val("rsp_valid", {31'h0, s_rsp(sel)}, {31'h0, rv_exp});
            if (rv_exp) begin
                e = eq.pop_front();
                if (e.kn) check_val(e.we ? "rdata_store" : "rdata_load", s_rdata(sel), e.d);
                if (!e.we) last_rd = s_rdata(sel);
                last_lat = t - e.acc;
            end
            busy_exp = (eq.size() > 0);
            check_val("busy", {31'h0, s_busy(sel)}, {31'h0, busy_exp});
            check_val("req_ready", {31'h0, s_ready(sel)}, {31'h0, !busy_exp});
            if (presenting && !busy_exp) begin
                model_apply(sel, cur, d, kn);
                eq.push_back('{cyc: t + ws + 1, d: d, kn: kn, we: cur.we, acc: t});
                presenting = 0;
            end
        end
        if (t >= limit) check_val("stream_timeout", 32'h0, 32'h1);
        ops.delete();
    endtask

    function automatic op_t mk(input bit we, input bit [9:0] a, input bit [31:0] d, input bit [3:0] be);
        op_t o;
        o.we = we; o.addr = a; o.wdata = d; o.be = be;
        return o;
    endfunction

    function automatic op_t rnd_op(input int max_addr);
        return mk(1'($urandom_range(1)), 10'($urandom_range(max_addr)), $urandom, 4'($urandom_range(15)));
    endfunction

    initial begin
        op_t o;
        for (int i = 0; i < 1024; i++) begin
            m2[i] = '0; m0[i] = '0; k2[i] = 0; k0[i] = 0;
        end
        last_rd  = '0;
        last_lat = 0;

        // Reset held with a request pending
        o = mk(1, 10'h001, 32'h1, 4'hF);
        drive(0, 1, o);
        drive(1, 1, o);
        repeat (3) @(negedge clk);
        check_val("rst_rsp_valid2", {31'h0, if2.rsp_valid}, 32'h0);
        check_val("rst_rdata2", if2.rsp_rdata, 32'h0);
        check_val("rst_busy2", {31'h0, if2.busy}, 32'h0);
        check_val("rst_rsp_valid0", {31'h0, if0.rsp_valid}, 32'h0);
        rst = 1'b1;
        drive(0, 0, o);
        drive(1, 0, o);
        @(negedge clk);
        check_val("rel_ready2", {31'h0, if2.req_ready}, 32'h1);
        check_val("rel_busy2", {31'h0, if2.busy}, 32'h0);
        check_val("rel_ready0", {31'h0, if0.req_ready}, 32'h1);
        check_val("rel_rsp_valid2", {31'h0, if2.rsp_valid}, 32'h0);

        // Store then load, three-cycle latency
        ops.push_back(mk(1, 10'h010, 32'hDEADBEEF, 4'hF));
        run_ops(0, 0, 2);
        check_val("t2_store_lat", last_lat, 32'd3);
        ops.push_back(mk(0, 10'h010, 32'h0, 4'h0));
        run_ops(0, 0, 2);
        check_val("t2_load_lat", last_lat, 32'd3);
        check_val("t2_load_data", last_rd, 32'hDEADBEEF);

        // Byte lanes and an empty byte-enable store
        ops.push_back(mk(1, 10'h020, 32'h11223344, 4'hF));
        ops.push_back(mk(1, 10'h020, 32'hAABBCCDD, 4'b0101));
        ops.push_back(mk(0, 10'h020, 32'h0, 4'h0));
        run_ops(0, 0, 2);
        check_val("t3_merge", last_rd, 32'h11BB33DD);
        ops.push_back(mk(1, 10'h020, 32'hFFFFFFFF, 4'h0));
        ops.push_back(mk(0, 10'h020, 32'h0, 4'h0));
        run_ops(0, 0, 2);
        check_val("t3_be0_unchanged", last_rd, 32'h11BB33DD);

        // Back-to-back store/load to one address
        ops.push_back(mk(1, 10'h055, 32'hA5A5A5A5, 4'hF));
        ops.push_back(mk(0, 10'h055, 32'h0, 4'h0));
        ops.push_back(mk(1, 10'h055, 32'h5A5A5A5A, 4'b1100));
        ops.push_back(mk(0, 10'h055, 32'h0, 4'h0));
        run_ops(0, 0, 2);
        check_val("t4_b2b_load", last_rd, 32'h5A5AA5A5);

        // Reset during WAIT drops the pending store
        ops.push_back(mk(1, 10'h3FF, 32'h12345678, 4'hF));
        run_ops(0, 0, 2);
        o = mk(1, 10'h3FF, 32'hCAFEF00D, 4'hF);
        @(posedge clk); #1; drive(0, 1, o);
        @(negedge clk);
        check_val("t5_ready", {31'h0, if2.req_ready}, 32'h1);
        @(posedge clk); #1; drive(0, 0, o);
        @(negedge clk);
        check_val("t5_busy", {31'h0, if2.busy}, 32'h1);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_val("t5_rsp_in_rst", {31'h0, if2.rsp_valid}, 32'h0);
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("t5_no_rsp", {31'h0, if2.rsp_valid}, 32'h0);
        end
        ops.push_back(mk(0, 10'h3FF, 32'h0, 4'h0));
        run_ops(0, 0, 2);
        check_val("t5_old_data", last_rd, 32'h12345678);

        // Random traffic on a small address window for collisions
        for (int i = 0; i < 300; i++) ops.push_back(rnd_op(31));
        run_ops(0, 30, 2);

        // Zero wait states: latency one, one request per cycle
        ops.push_back(mk(1, 10'h100, 32'h0BADF00D, 4'hF));
        run_ops(1, 0, 0);
        check_val("t6_store_lat", last_lat, 32'd1);
        ops.push_back(mk(0, 10'h100, 32'h0, 4'h0));
        run_ops(1, 0, 0);
        check_val("t6_load_lat", last_lat, 32'd1);
        check_val("t6_load_data", last_rd, 32'h0BADF00D);
        for (int i = 0; i < 1024; i++) ops.push_back(mk(1, 10'(i), $urandom, 4'hF));
        run_ops(1, 0, 0);
        for (int i = 0; i < 2000; i++) ops.push_back(rnd_op(1023));
        run_ops(1, 10, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
